// File: rtl/top_stim_pkg.sv
// Shared types and LFSR helper for the top_stim_driver stimulus/check block.
package top_stim_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int          LFSR_W    = 16;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // One step of the Galois right-shift LFSR.
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? LFSR_TAPS : 16'h0000);
  endfunction

endpackage

// File: rtl/top_stim_lfsr.sv
// 16-bit Galois LFSR with synchronous load/advance; a zero seed is replaced
// by 1 so the register can never lock up in the all-zero state.
module top_stim_lfsr
  import top_stim_pkg::*;
#(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int          WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_advance,
  output logic [WIDTH-1:0] o_vec
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

  logic [LFSR_W-1:0] r_lfsr;

  // Seed on reset or load, otherwise step once per advance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_lfsr <= SEED_EFF;
    end else if (i_load) begin
      r_lfsr <= SEED_EFF;
    end else if (i_advance) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  assign o_vec = r_lfsr[WIDTH-1:0];

endmodule

// File: rtl/top_stim_driver.sv
// Bindable stimulus-and-check block for Top: drives LFSR vectors on I,
// predicts O as I delayed by LATENCY cycles and counts mismatches.
// Typical attachment:
//   bind Top top_stim_driver top_stim_driver_inst (.CLK(CLK),
//     .ASYNCRESETN(ASYNCRESETN), .I(I), .O(O), .start(...), .busy(...),
//     .done(...), .mismatch(...), .err_count(...));
module top_stim_driver
  import top_stim_pkg::*;
#(
  parameter int          WIDTH       = 1,
  parameter int          LATENCY     = 1,
  parameter int          NUM_VECTORS = 16,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          CNT_W       = 8
) (
  input  logic             CLK,
  input  logic             ASYNCRESETN,
  input  logic             start,
  output logic [WIDTH-1:0] I,
  input  logic [WIDTH-1:0] O,
  output logic             busy,
  output logic             done,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count
);

  // The phase counter times both RUN (NUM_VECTORS cycles) and DRAIN
  // (LATENCY+1 cycles), so it is sized for the longer of the two.
  localparam int PHASE_MAX = (NUM_VECTORS > LATENCY + 1) ? NUM_VECTORS : LATENCY + 1;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam logic [PW-1:0] RUN_LAST   = PW'(NUM_VECTORS - 1);
  localparam logic [PW-1:0] DRAIN_LAST = PW'(LATENCY);

  state_t            r_state;
  state_t            w_nextState;
  logic [PW-1:0]     r_phaseCnt;
  logic              w_lfsrLoad;
  logic              w_lfsrAdvance;
  logic              w_clearErr;
  logic [WIDTH-1:0]  w_lfsrVec;
  logic [LATENCY-1:0] r_pipeValid;
  logic [WIDTH-1:0]  r_pipeData [LATENCY];
  logic              w_cmpFail;
  logic              r_mismatch;
  logic [CNT_W-1:0]  r_errCount;

  top_stim_lfsr #(
    .SEED  (SEED),
    .WIDTH (WIDTH)
  ) u_lfsr (
    .i_clk     (CLK),
    .i_rst_n   (ASYNCRESETN),
    .i_load    (w_lfsrLoad),
    .i_advance (w_lfsrAdvance),
    .o_vec     (w_lfsrVec)
  );

  // FSM state register.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state decode plus the stimulus, status and LFSR control outputs.
  always_comb begin
    w_nextState   = r_state;
    I             = '0;
    busy          = 1'b0;
    done          = 1'b0;
    w_lfsrLoad    = 1'b0;
    w_lfsrAdvance = 1'b0;
    w_clearErr    = 1'b0;
    case (r_state)
      IDLE: begin
        w_lfsrLoad = 1'b1;
        w_clearErr = 1'b1;
        if (start) w_nextState = RUN;
      end
      RUN: begin
        I             = w_lfsrVec;
        busy          = 1'b1;
        w_lfsrAdvance = 1'b1;
        if (r_phaseCnt == RUN_LAST) w_nextState = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (r_phaseCnt == DRAIN_LAST) w_nextState = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_nextState = RUN;
          w_lfsrLoad  = 1'b1;
          w_clearErr  = 1'b1;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // Phase counter restarts on every state change and counts cycles within RUN/DRAIN.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_phaseCnt <= '0;
    end else if (r_state != w_nextState) begin
      r_phaseCnt <= '0;
    end else if ((r_state == RUN) || (r_state == DRAIN)) begin
      r_phaseCnt <= r_phaseCnt + PW'(1);
    end
  end

  // Expected-value shift pipeline; only vectors issued in RUN are marked valid.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_pipeValid <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        r_pipeData[i] <= '0;
      end
    end else begin
      r_pipeValid[0] <= (r_state == RUN);
      r_pipeData[0]  <= I;
      for (int i = 1; i < LATENCY; i++) begin
        r_pipeValid[i] <= r_pipeValid[i-1];
        r_pipeData[i]  <= r_pipeData[i-1];
      end
    end
  end

  assign w_cmpFail = r_pipeValid[LATENCY-1] && (r_pipeData[LATENCY-1] != O);

  // Registered mismatch pulse and saturating error counter.
  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      r_mismatch <= 1'b0;
      r_errCount <= '0;
    end else begin
      r_mismatch <= w_cmpFail;
      if (w_clearErr) begin
        r_errCount <= '0;
      end else if (w_cmpFail && (r_errCount != {CNT_W{1'b1}})) begin
        r_errCount <= r_errCount + CNT_W'(1);
      end
    end
  end

  assign mismatch  = r_mismatch;
  assign err_count = r_errCount;

endmodule

// File: tb/tb_top_stim_driver.sv
// Bench for top_stim_driver: two instances (1-bit/latency-1/2-bit counter and
// 4-bit/latency-3/zero seed) against bench-modelled Top stand-ins.
module tb_top_stim_driver;

  localparam int NA = 16;
  localparam int LA = 1;
  localparam int NB = 16;
  localparam int LB = 3;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        mism;
    logic [15:0] iv;
    logic [31:0] err;
  } exp_t;

  logic CLK    = 1'b0;
  logic rstn   = 1'b1;
  logic startA = 1'b0;
  logic startB = 1'b0;

  logic       IA, OA, busyA, doneA, mismA;
  logic [1:0] errA;
  logic [3:0] IB, OB;
  logic       busyB, doneB, mismB;
  logic [7:0] errB;

  int nCompared   = 0;
  int nMismatched = 0;

  int          cA = 0;
  int          cB = 0;
  logic [31:0] badMaskA  = 32'h0;
  logic [31:0] runBadA   = 32'h0;
  logic        invertAll = 1'b0;
  logic        rTopA     = 1'b0;
  logic [11:0] dlB       = 12'h0;
  int          idxA;
  logic        flipA;
  exp_t        eA, eB;

  top_stim_driver #(
    .WIDTH(1), .LATENCY(LA), .NUM_VECTORS(NA), .SEED(16'hACE1), .CNT_W(2)
  ) dutA (
    .CLK(CLK), .ASYNCRESETN(rstn), .start(startA), .I(IA), .O(OA),
    .busy(busyA), .done(doneA), .mismatch(mismA), .err_count(errA)
  );

  top_stim_driver #(
    .WIDTH(4), .LATENCY(LB), .NUM_VECTORS(NB), .SEED(16'h0000), .CNT_W(8)
  ) dutB (
    .CLK(CLK), .ASYNCRESETN(rstn), .start(startB), .I(IB), .O(OB),
    .busy(busyB), .done(doneB), .mismatch(mismB), .err_count(errB)
  );

  always #5 CLK = ~CLK;

  function automatic logic [15:0] stepLfsr(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Expected outputs c cycles after an accepted start (c=0 means idle since reset).
  function automatic exp_t expectAt(input int c, input int n, input int lat,
                                    input logic [15:0] seed, input logic [15:0] wmask,
                                    input int sat, input logic [31:0] bad);
    exp_t        e;
    logic [15:0] l;
    int          k;
    int          cnt;
    e.busy = (c >= 1) && (c <= n + lat + 1);
    e.done = (c >= n + lat + 2);
    e.iv   = 16'h0;
    if (c >= 1 && c <= n) begin
      l = (seed == 16'h0) ? 16'h0001 : seed;
      for (int j = 0; j < c - 1; j++) l = stepLfsr(l);
      e.iv = l & wmask;
    end
    k      = c - lat - 2;
    e.mism = (k >= 0 && k < n) ? bad[k[4:0]] : 1'b0;
    cnt    = 0;
    for (int j = 0; j < n; j++) if (j <= k && bad[j]) cnt++;
    e.err = 32'((cnt > sat) ? sat : cnt);
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Run position of each instance, tracked from the start pulses the bench issues.
  always @(posedge CLK or negedge rstn) begin
    if (!rstn) begin
      cA <= 0;
      cB <= 0;
    end else begin
      if (startA && (cA == 0 || cA >= NA + LA + 2)) begin
        cA      <= 1;
        runBadA <= badMaskA;
      end else if (cA != 0 && cA < 1000) begin
        cA <= cA + 1;
      end
      if (startB && (cB == 0 || cB >= NB + LB + 2)) cB <= 1;
      else if (cB != 0 && cB < 1000) cB <= cB + 1;
    end
  end

  // Top stand-ins: A is a 1-cycle register with optional inversion, B a 3-stage delay.
  always @(posedge CLK) begin
    rTopA <= IA;
    dlB   <= {dlB[7:0], IB};
  end

  always_comb begin
    idxA  = cA - LA - 1;
    flipA = invertAll || ((idxA >= 0) && (idxA < NA) && runBadA[idxA[4:0]]);
    OA    = rTopA ^ flipA;
    OB    = dlB[11:8];
  end

  // Per-cycle compare of both instances against the model.
  always @(negedge CLK) begin
    if (rstn) begin
      eA = expectAt(cA, NA, LA, 16'hACE1, 16'h0001, 3, runBadA);
      eB = expectAt(cB, NB, LB, 16'h0000, 16'h000F, 255, 32'h0);
      checkOutput("A.I",        32'(IA),    32'(eA.iv));
      checkOutput("A.busy",     32'(busyA), 32'(eA.busy));
      checkOutput("A.done",     32'(doneA), 32'(eA.done));
      checkOutput("A.mismatch", 32'(mismA), 32'(eA.mism));
      checkOutput("A.err",      32'(errA),  eA.err);
      checkOutput("B.I",        32'(IB),    32'(eB.iv));
      checkOutput("B.busy",     32'(busyB), 32'(eB.busy));
      checkOutput("B.done",     32'(doneB), 32'(eB.done));
      checkOutput("B.mismatch", 32'(mismB), 32'(eB.mism));
      checkOutput("B.err",      32'(errB),  eB.err);
    end
  end

  task automatic applyStimulus(input bit selB);
    @(posedge CLK);
    #1;
    if (selB) startB = 1'b1; else startA = 1'b1;
    @(posedge CLK);
    #1;
    startA = 1'b0;
    startB = 1'b0;
  endtask

  // Start a run and observe it until done; optionally pulse start in RUN and DRAIN.
  task automatic runOnce(input bit selB, input bit poke, output int doneCyc,
                         output logic [63:0] fv, output int pulses, output int firstMis,
                         output int errAt1, output int errFinal);
    logic [15:0] i;
    logic        d, m;
    int          e;
    doneCyc  = -1;
    fv       = 64'h0;
    pulses   = 0;
    firstMis = -1;
    errAt1   = -1;
    errFinal = -1;
    applyStimulus(selB);
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge CLK);
      if (selB) begin
        i = 16'(IB); d = doneB; m = mismB; e = int'(errB);
      end else begin
        i = 16'(IA); d = doneA; m = mismA; e = int'(errA);
      end
      if (cyc <= 4) fv[(cyc-1)*16 +: 16] = i;
      if (cyc == 1) errAt1 = e;
      if (m) begin
        pulses++;
        if (firstMis < 0) firstMis = cyc;
      end
      if (selB) startB = poke && (cyc == 3 || cyc == 17);
      else      startA = poke && (cyc == 3 || cyc == 17);
      if (d) begin
        doneCyc  = cyc - 1;
        errFinal = e;
        break;
      end
    end
    startA = 1'b0;
    startB = 1'b0;
    if (doneCyc < 0) checkOutput("done_timeout", 32'(doneCyc), 32'd0);
  endtask

  initial begin
    int          doneCyc, pulses, firstMis, errAt1, errFinal, cnt;
    logic [63:0] fv;

    #2 rstn = 1'b0;
    #20;
    checkOutput("rst.A.I",    32'(IA),    32'd0);
    checkOutput("rst.A.busy", 32'(busyA), 32'd0);
    checkOutput("rst.A.done", 32'(doneA), 32'd0);
    checkOutput("rst.A.mism", 32'(mismA), 32'd0);
    checkOutput("rst.A.err",  32'(errA),  32'd0);
    checkOutput("rst.B.I",    32'(IB),    32'd0);
    checkOutput("rst.B.busy", 32'(busyB), 32'd0);
    checkOutput("rst.B.done", 32'(doneB), 32'd0);
    checkOutput("rst.B.mism", 32'(mismB), 32'd0);
    checkOutput("rst.B.err",  32'(errB),  32'd0);
    #1 rstn = 1'b1;

    $display("[TB] ideal run, latency 1");
    runOnce(1'b0, 1'b0, doneCyc, fv, pulses, firstMis, errAt1, errFinal);
    checkOutput("t1.first4",  32'({fv[0], fv[16], fv[32], fv[48]}), 32'b1000);
    checkOutput("t1.doneCyc", 32'(doneCyc),  32'd18);
    checkOutput("t1.pulses",  32'(pulses),   32'd0);
    checkOutput("t1.err",     32'(errFinal), 32'd0);

    $display("[TB] single fault on 5th compare");
    badMaskA = 32'h0000_0010;
    runOnce(1'b0, 1'b0, doneCyc, fv, pulses, firstMis, errAt1, errFinal);
    checkOutput("t2.pulses",   32'(pulses),   32'd1);
    checkOutput("t2.firstMis", 32'(firstMis), 32'd7);
    checkOutput("t2.err",      32'(errFinal), 32'd1);
    checkOutput("t2.doneCyc",  32'(doneCyc),  32'd18);

    $display("[TB] start ignored in RUN and DRAIN, restart from DONE");
    badMaskA = 32'h0;
    runOnce(1'b0, 1'b1, doneCyc, fv, pulses, firstMis, errAt1, errFinal);
    checkOutput("t5.errAt1",  32'(errAt1),  32'd0);
    checkOutput("t5.doneCyc", 32'(doneCyc), 32'd18);
    checkOutput("t5.pulses",  32'(pulses),  32'd0);

    $display("[TB] saturation with every compare failing");
    badMaskA  = 32'h0000_FFFF;
    invertAll = 1'b1;
    runOnce(1'b0, 1'b0, doneCyc, fv, pulses, firstMis, errAt1, errFinal);
    checkOutput("t3.pulses", 32'(pulses),   32'd16);
    checkOutput("t3.err",    32'(errFinal), 32'd3);

    $display("[TB] reset during RUN cycle 5");
    applyStimulus(1'b0);
    repeat (5) @(negedge CLK);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t4.I",    32'(IA),    32'd0);
    checkOutput("t4.busy", 32'(busyA), 32'd0);
    checkOutput("t4.done", 32'(doneA), 32'd0);
    checkOutput("t4.mism", 32'(mismA), 32'd0);
    checkOutput("t4.err",  32'(errA),  32'd0);
    @(posedge CLK);
    @(posedge CLK);
    #2 rstn = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      if (mismA) cnt++;
    end
    checkOutput("t4.postPulses", 32'(cnt), 32'd0);
    invertAll = 1'b0;
    badMaskA  = 32'h0;
    runOnce(1'b0, 1'b0, doneCyc, fv, pulses, firstMis, errAt1, errFinal);
    checkOutput("t4.first4",  32'({fv[0], fv[16], fv[32], fv[48]}), 32'b1000);
    checkOutput("t4.doneCyc", 32'(doneCyc), 32'd18);

    $display("[TB] latency 3, zero seed, 4-bit");
    runOnce(1'b1, 1'b0, doneCyc, fv, pulses, firstMis, errAt1, errFinal);
    checkOutput("t6.vec0",    32'(fv[15:0]),  32'h1);
    checkOutput("t6.vec1",    32'(fv[31:16]), 32'h0);
    checkOutput("t6.doneCyc", 32'(doneCyc),   32'd20);
    checkOutput("t6.pulses",  32'(pulses),    32'd0);
    checkOutput("t6.err",     32'(errFinal),  32'd0);

    repeat (3) @(negedge CLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule

// File: doc/top_stim_driver.md
# top_stim_driver

Bindable, synthesizable stimulus-and-check block: the driving counterpart to a passive bound monitor on Top's I/O. It drives a pseudo-random vector sequence onto Top's input `I`, predicts Top's output `O` as `I` delayed by `LATENCY` cycles, and compares the two. It counts mismatches and signals completion. It is attached to Top with a `bind` statement and sits beside Top in simulation or FPGA smoke builds.

## Interface
Parameters:
- `WIDTH`, 1 — width of `I`/`O`; legal range 1..16.
- `LATENCY`, 1 — Top's I-to-O latency in cycles; minimum 1.
- `NUM_VECTORS`, 16 — vectors per run; minimum 1.
- `SEED`, 16'hACE1 — LFSR seed. A value of 0 is replaced by 16'h0001.
- `CNT_W`, 8 — width of `err_count`.

Ports:
- `CLK` in 1 — clock, rising edge.
- `ASYNCRESETN` in 1 — asynchronous, active-low reset.
- `start` in 1 — single-cycle request to begin a run.
- `I` out WIDTH — stimulus driven to Top.
- `O` in WIDTH — Top's response.
- `busy` out 1 — high in RUN and DRAIN.
- `done` out 1 — high in DONE.
- `mismatch` out 1 — registered one-cycle pulse for each failed compare.
- `err_count` out CNT_W — saturating count of mismatches in the current run.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- **IDLE**
  - `start` moves the FSM to RUN.
  - The LFSR loads SEED, and the vector counter and `err_count` clear.
- **RUN**
  - `I = lfsr[WIDTH-1:0]`.
  - The LFSR advances every cycle: Galois right shift with taps 16'hB400, so `next = (l>>1) ^ (l[0] ? 16'hB400 : 0)`.
  - After NUM_VECTORS cycles the FSM moves to DRAIN.
- **DRAIN**
  - `I = 0`.
  - Lasts LATENCY+1 cycles, so the last compare and its registered `mismatch` can retire.
  - Then the FSM moves to DONE.
- **DONE**
  - `err_count` holds its value.
  - `start` re-enters RUN with a reseed and cleared counters.
- **Expected-value pipeline**
  - The pipeline is LATENCY stages deep and carries `{valid, data}`. `valid` is 1 only for vectors issued in RUN.
  - When an entry exits with `valid=1`, it is compared against `O`. Inequality sets `mismatch` on the next cycle and increments `err_count`.
  - `err_count` saturates at 2^CNT_W−1 and does not wrap.
- `start` is ignored in RUN and DRAIN.

## Timing
- **Reset values:** state=IDLE, `I`=0, `busy`=0, `done`=0, `mismatch`=0, `err_count`=0, LFSR=SEED (or 1 if SEED is 0), and all pipeline valid bits 0.
- **Reset mid-run:** the block returns immediately to IDLE with all of the above values, and no compare fires afterward.
- **Start:** `start` high at edge k puts the first vector on `I` in cycle k+1, with `busy` high from k+1.
- **Compare timing:** vector n, driven in cycle t, is compared against `O` sampled in cycle t+LATENCY. A failing compare shows `mismatch` in cycle t+LATENCY+1.
- **Run length:** `done` rises exactly NUM_VECTORS + LATENCY + 1 cycles after `busy` rises.
- **Saturation:** a mismatch that arrives while `err_count` is saturated still pulses `mismatch`.

## Structure
- **Package `top_stim_pkg`:**
  - `state_t` enum (IDLE, RUN, DRAIN, DONE).
  - `LFSR_TAPS = 16'hB400`.
  - Function `lfsr_next(logic [15:0])`.
- **Sub-module `top_stim_lfsr`:**
  - 16-bit register with `load`/`advance` inputs.
  - Seed-zero substitution happens inside it.
- The top level holds the FSM, the counters, the expected-value shift pipeline, and the comparator.
- Attach with `bind Top top_stim_driver top_stim_driver_inst (.CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .I(I), .O(O), ...)`.

## Test plan
1. **Ideal DUT, LATENCY=1:** WIDTH=1, SEED=16'hACE1, `O` wired as a 1-cycle register of `I`, pulse `start` → `I` reads 1,0,0,0 in the first four RUN cycles; `done` rises 18 cycles after `busy`; `err_count`=0; `mismatch` never asserts.
2. **Single injected fault:** same setup, but force `O` inverted on the 5th compare only → exactly one `mismatch` pulse, one cycle after that compare; final `err_count`=1.
3. **Saturation:** CNT_W=2, `O` held at constant inverse of expected, NUM_VECTORS=16 → `err_count` stops at 3; `mismatch` pulses 16 times.
4. **Reset mid-run:** `ASYNCRESETN` low during RUN cycle 5 → outputs go to reset values without waiting for a clock edge; no `mismatch` occurs after release; a new `start` reproduces sequence 1,0,0,0.
5. **Busy/done handling:** `start` pulsed during RUN and DRAIN → ignored, cycle counts unchanged. `start` in DONE → new run with `err_count` cleared to 0.
6. **LATENCY=3, SEED=0, WIDTH=4:** LFSR uses seed 1, so the first vector is 4'h1; `done` rises NUM_VECTORS+4 cycles after `busy`; `err_count`=0 against a 3-stage ideal DUT.
